// File: rtl/tick_chain_pkg.sv
// tick_chain_pkg: defaults and packing helpers shared by the tick chain.
// Revision: 1.0
`default_nettype none

package tick_chain_pkg;

   localparam int          NST_DEF      = 3;
   localparam int          W_DEF        = 16;
   localparam logic [47:0] DIV_INIT_DEF = {16'd100, 16'd15625, 16'd32};
   localparam int          VEC_MAX      = 256;

   function automatic logic [31:0] div_eff(input logic [31:0] d);
      return (d == 32'd0) ? 32'd1 : d;
   endfunction

   // Extract stage k (w bits wide) from a packed divisor vector.
   function automatic logic [31:0] stage_slice(input logic [VEC_MAX-1:0] vec,
                                               input int k, input int w);
      logic [VEC_MAX-1:0] mask;
      mask = (VEC_MAX'(1) << w) - VEC_MAX'(1);
      return 32'((vec >> (k * w)) & mask);
   endfunction

endpackage

`default_nettype wire

// File: rtl/tick_chain_if.sv
// tick_chain_if: enable/load/divisor inputs and tick outputs of the chain.
// Revision: 1.0 (Sq present only with TICK_SQUARE_EN)
`default_nettype none

interface tick_chain_if #(
   parameter int NST = 3,
   parameter int W   = 16
);
   logic             En;
   logic             Load;
   logic [NST*W-1:0] DivIn;
   logic [NST-1:0]   Tick;
`ifdef TICK_SQUARE_EN
   logic [NST-1:0]   Sq;
`endif

   modport master (
      output En, Load, DivIn,
`ifdef TICK_SQUARE_EN
      input  Sq,
`endif
      input  Tick
   );

   modport slave (
      input  En, Load, DivIn,
`ifdef TICK_SQUARE_EN
      output Sq,
`endif
      output Tick
   );
endinterface

`default_nettype wire

// File: rtl/tick_stage.sv
// tick_stage: one divisor register, modulus counter and tick flop.
// Revision: 1.0 (optional square-wave flop with TICK_SQUARE_EN)
`default_nettype none

module tick_stage
   import tick_chain_pkg::*;
#(
   parameter int           W       = 16,
   parameter logic [W-1:0] DIV_RST = '0
) (
   input  wire         Clk,
   input  wire         Clr_,
   input  wire         ClrS_,
   input  wire         Load,
   input  wire         tick_in,
   input  wire [W-1:0] div_new,
`ifdef TICK_SQUARE_EN
   output logic        sq,
`endif
   output logic        tick
);

   logic [W-1:0] div_q;
   logic [W-1:0] cnt;
   logic [W-1:0] div_e;
   logic         last;
   logic         clear;

   assign div_e = W'(div_eff(32'(div_q)));
   assign last  = (cnt == div_e - W'(1));
   assign clear = Load || !ClrS_;

   always_ff @(posedge Clk or negedge Clr_) begin
      if (!Clr_) begin
         div_q <= DIV_RST;
         cnt   <= '0;
         tick  <= 1'b0;
      end else begin
         if (Load)
            div_q <= div_new;
         if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
         end else if (tick_in) begin
            if (last) begin
               cnt  <= '0;
               tick <= 1'b1;
            end else begin
               cnt  <= cnt + W'(1);
               tick <= 1'b0;
            end
         end else begin
            tick <= 1'b0;
         end
      end
   end

`ifdef TICK_SQUARE_EN
   // Toggles exactly when the tick flop is being set.
   always_ff @(posedge Clk or negedge Clr_) begin
      if (!Clr_)
         sq <= 1'b0;
      else if (clear)
         sq <= 1'b0;
      else if (tick_in && last)
         sq <= ~sq;
   end
`endif

endmodule

`default_nettype wire

// File: rtl/tick_chain.sv
// tick_chain: cascade of NST tick_stage dividers producing clock-enable ticks.
// Revision: 1.0 (TICK_SQUARE_EN adds square-wave outputs)
`default_nettype none

module tick_chain
   import tick_chain_pkg::*;
#(
   parameter int               NST      = NST_DEF,
   parameter int               W        = W_DEF,
   parameter logic [NST*W-1:0] DIV_INIT = DIV_INIT_DEF
) (
   input  wire          Clk,
   input  wire          Clr_,
   input  wire          ClrS_,
   tick_chain_if.slave  bus
);

   logic [NST-1:0] tick;
   logic [NST-1:0] tick_in;
`ifdef TICK_SQUARE_EN
   logic [NST-1:0] sq;
   assign bus.Sq = sq;
`endif

   assign bus.Tick = tick;

   for (genvar k = 0; k < NST; k++) begin : g_stage
      localparam logic [W-1:0] DIV_RST = W'(stage_slice(VEC_MAX'(DIV_INIT), k, W));
      logic [W-1:0] div_new;

      assign div_new = W'(stage_slice(VEC_MAX'(bus.DivIn), k, W));

      if (k == 0) begin : g_first
         assign tick_in[k] = bus.En;
      end else begin : g_next
         assign tick_in[k] = tick[k-1] & bus.En;
      end

      tick_stage #(
         .W       (W),
         .DIV_RST (DIV_RST)
      ) u_stage (
         .Clk     (Clk),
         .Clr_    (Clr_),
         .ClrS_   (ClrS_),
         .Load    (bus.Load),
         .tick_in (tick_in[k]),
         .div_new (div_new),
`ifdef TICK_SQUARE_EN
         .sq      (sq[k]),
`endif
         .tick    (tick[k])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_tick_chain.sv
// tb_tick_chain: directed self-checking bench, NST=3, W=4, reset divisors 3/2/4.
`default_nettype none

module tb_tick_chain;

   logic Clk = 1'b0;
   logic Clr_;
   logic ClrS_;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 Clk = ~Clk;

   tick_chain_if #(.NST(3), .W(4)) bus ();

   tick_chain #(
      .NST      (3),
      .W        (4),
      .DIV_INIT ({4'd4, 4'd2, 4'd3})
   ) dut (
      .Clk   (Clk),
      .Clr_  (Clr_),
      .ClrS_ (ClrS_),
      .bus   (bus)
   );

   // Expected ticks for reset divisors 3,2,4 after enabled edge e (e >= 1).
   function automatic logic [2:0] exp_init(input int e);
      logic [2:0] v;
      v[0] = (e % 3 == 0);
      v[1] = (e >= 7)  && ((e - 7) % 6 == 0);
      v[2] = (e >= 26) && ((e - 26) % 24 == 0);
      return v;
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Clr_      = 1'b0;
      ClrS_     = 1'b1;
      bus.En    = 1'b0;
      bus.Load  = 1'b0;
      bus.DivIn = '0;
      @(negedge Clk);
      Clr_ = 1'b1;
      step();
   endtask

   task automatic test_reset();
      @(negedge Clk);
      Clr_      = 1'b0;
      ClrS_     = 1'b1;
      bus.En    = 1'b1;
      bus.Load  = 1'b0;
      bus.DivIn = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (bus.Tick !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_tick cycle %0d: Tick=%b expected 000", i, bus.Tick);
         end
`ifdef TICK_SQUARE_EN
         n_checks++;
         if (bus.Sq !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_sq cycle %0d: Sq=%b expected 000", i, bus.Sq);
         end
`endif
      end
      bus.En = 1'b0;
      @(negedge Clk);
      Clr_ = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (bus.Tick !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_tick cycle %0d: Tick=%b expected 000", i, bus.Tick);
         end
      end
   endtask

   task automatic test_cascade();
      do_reset();
      bus.En = 1'b1;
      for (int e = 1; e <= 52; e++) begin
         step();
         n_checks++;
         if (bus.Tick !== exp_init(e)) begin
            n_fail++;
            $display("FAIL cascade edge %0d: Tick=%b expected %b", e, bus.Tick, exp_init(e));
         end
      end
   endtask

   task automatic test_enable_gap();
      logic [2:0] exp_after [4];
      exp_after = '{3'b000, 3'b001, 3'b010, 3'b000};
      do_reset();
      bus.En = 1'b1;
      for (int e = 1; e <= 4; e++) step();
      bus.En = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (bus.Tick !== 3'b000) begin
            n_fail++;
            $display("FAIL gap_tick cycle %0d: Tick=%b expected 000", i, bus.Tick);
         end
      end
      bus.En = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (bus.Tick !== exp_after[i]) begin
            n_fail++;
            $display("FAIL gap_resume edge %0d: Tick=%b expected %b", i + 5, bus.Tick, exp_after[i]);
         end
      end
   endtask

   task automatic test_load();
      logic [2:0] exp_v [8];
      exp_v = '{3'b000, 3'b001, 3'b011, 3'b011, 3'b111, 3'b011, 3'b111, 3'b011};
      do_reset();
      bus.En = 1'b1;
      for (int e = 1; e <= 9; e++) step();
      bus.Load  = 1'b1;
      bus.DivIn = {4'd2, 4'd1, 4'd0};
      for (int i = 0; i < 8; i++) begin
         step();
         bus.Load = 1'b0;
         n_checks++;
         if (bus.Tick !== exp_v[i]) begin
            n_fail++;
            $display("FAIL load edge %0d: Tick=%b expected %b", i + 10, bus.Tick, exp_v[i]);
         end
      end
   endtask

   task automatic test_clear_priority();
      logic [2:0] exp_v [6];
      exp_v = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b101, 3'b010};
      do_reset();
      bus.En = 1'b1;
      for (int e = 1; e <= 5; e++) step();
      bus.Load  = 1'b1;
      ClrS_     = 1'b0;
      bus.DivIn = {4'd1, 4'd1, 4'd2};
      for (int i = 0; i < 6; i++) begin
         step();
         bus.Load = 1'b0;
         ClrS_    = 1'b1;
         n_checks++;
         if (bus.Tick !== exp_v[i]) begin
            n_fail++;
            $display("FAIL load_clrs edge %0d: Tick=%b expected %b", i, bus.Tick, exp_v[i]);
         end
      end
      // ClrS_ alone keeps the loaded divisors.
      ClrS_ = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         ClrS_ = 1'b1;
         n_checks++;
         if (bus.Tick !== exp_v[i]) begin
            n_fail++;
            $display("FAIL clrs_only edge %0d: Tick=%b expected %b", i, bus.Tick, exp_v[i]);
         end
      end
      #1;
      Clr_ = 1'b0;
      #1;
      n_checks++;
      if (bus.Tick !== 3'b000) begin
         n_fail++;
         $display("FAIL async_clr: Tick=%b expected 000", bus.Tick);
      end
      #2;
      Clr_ = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step();
         n_checks++;
         if (bus.Tick !== exp_init(e)) begin
            n_fail++;
            $display("FAIL div_restore edge %0d: Tick=%b expected %b", e, bus.Tick, exp_init(e));
         end
      end
   endtask

`ifdef TICK_SQUARE_EN
   task automatic test_square();
      logic exp_sq;
      do_reset();
      bus.En = 1'b1;
      for (int e = 1; e <= 13; e++) begin
         step();
         exp_sq = ((e / 3) % 2) == 1;
         n_checks++;
         if (bus.Sq[0] !== exp_sq) begin
            n_fail++;
            $display("FAIL square edge %0d: Sq0=%b expected %b", e, bus.Sq[0], exp_sq);
         end
      end
      ClrS_ = 1'b0;
      step();
      ClrS_ = 1'b1;
      n_checks++;
      if (bus.Sq !== 3'b000) begin
         n_fail++;
         $display("FAIL square_clrs: Sq=%b expected 000", bus.Sq);
      end
   endtask
`endif

   initial begin
      Clr_      = 1'b0;
      ClrS_     = 1'b1;
      bus.En    = 1'b0;
      bus.Load  = 1'b0;
      bus.DivIn = '0;
      test_reset();
      test_cascade();
      test_enable_gap();
      test_load();
      test_clear_priority();
`ifdef TICK_SQUARE_EN
      test_square();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
